// File: rtl/vga_rx.sv
// VGA receiver: measures incoming sync timing against the configured mode and
// recovers active-area pixels with their coordinates once the timing is trusted.
module vga_rx #(
    parameter int H_ACTIVE = 640,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_TOTAL  = 525
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [3:0] red,
    input  logic [3:0] green,
    input  logic [3:0] blue,
    output logic       locked,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [3:0] pix_r,
    output logic [3:0] pix_g,
    output logic [3:0] pix_b,
    output logic       frame_start,
    output logic       err,
    output logic [7:0] err_count
);

    // state  | meaning
    // SEARCH | no trusted timing, waiting for a vsync assertion
    // ALIGN  | measuring one full frame; any error restarts the window
    // LOCKED | timing verified, active pixels are forwarded
    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_END   = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);

    state_t      state, state_nxt;
    logic        hs_q, hs_qq, vs_q, vs_qq;
    logic [3:0]  r_q, g_q, b_q;
    logic [10:0] p_reg, p_cur;
    logic [9:0]  l_reg, l_cur;
    logic        v_pend, h_seen, h_armed, v_seen, dirty;
    logic        hs_fall, hs_rise, vs_fall;
    logic        h_err, v_err, err_now, active;

    assign hs_fall = hs_qq & ~hs_q;
    assign hs_rise = ~hs_qq & hs_q;
    assign vs_fall = vs_qq & ~vs_q;

    always_comb begin
        p_cur = (p_reg == 11'h7FF) ? p_reg : p_reg + 11'd1;
        l_cur = l_reg;
        if (hs_fall) begin
            p_cur = 11'd0;
            // the first line after a vsync assertion (including a coincident one) is line 0
            if (v_pend || vs_fall)
                l_cur = 10'd0;
            else if (l_reg != 10'h3FF)
                l_cur = l_reg + 10'd1;
        end
    end

    // width check waits for a second fall so a pulse cut short by reset is ignored
    assign h_err = (hs_fall && h_seen && (({1'b0, p_reg} + 12'd1) != 12'(H_TOTAL)))
                || (hs_rise && h_armed && (p_cur != 11'(H_SYNC)));
    assign v_err = vs_fall && v_seen && (({1'b0, l_reg} + 11'd1) != 11'(V_TOTAL));
    assign err_now = h_err || v_err;

    assign active = (p_cur >= H_START) && (p_cur < H_END)
                 && (l_cur >= V_START) && (l_cur < V_END);

    assign locked = (state == LOCKED);

    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH: if (vs_fall) state_nxt = ALIGN;
            ALIGN:  if (vs_fall && !dirty && !err_now) state_nxt = LOCKED;
            LOCKED: if (err_now) state_nxt = SEARCH;
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= SEARCH;
            hs_q        <= 1'b1;
            hs_qq       <= 1'b1;
            vs_q        <= 1'b1;
            vs_qq       <= 1'b1;
            r_q         <= 4'd0;
            g_q         <= 4'd0;
            b_q         <= 4'd0;
            p_reg       <= 11'd0;
            l_reg       <= 10'd0;
            v_pend      <= 1'b0;
            h_seen      <= 1'b0;
            h_armed     <= 1'b0;
            v_seen      <= 1'b0;
            dirty       <= 1'b0;
            pix_valid   <= 1'b0;
            pix_x       <= 10'd0;
            pix_y       <= 10'd0;
            pix_r       <= 4'd0;
            pix_g       <= 4'd0;
            pix_b       <= 4'd0;
            frame_start <= 1'b0;
            err         <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            state   <= state_nxt;
            hs_q    <= hsync;
            hs_qq   <= hs_q;
            vs_q    <= vsync;
            vs_qq   <= vs_q;
            r_q     <= red;
            g_q     <= green;
            b_q     <= blue;
            p_reg   <= p_cur;
            l_reg   <= l_cur;
            v_pend  <= hs_fall ? 1'b0 : (v_pend | vs_fall);
            h_seen  <= h_seen | hs_fall;
            h_armed <= h_armed | (hs_fall & h_seen);
            v_seen  <= v_seen | vs_fall;

            // a new alignment window opens on entry to ALIGN and on every vsync inside it
            if (state_nxt == ALIGN && (state != ALIGN || vs_fall))
                dirty <= 1'b0;
            else if (err_now)
                dirty <= 1'b1;

            pix_valid <= active && (state == LOCKED);
            if (active && state == LOCKED) begin
                pix_x <= 10'(p_cur - H_START);
                pix_y <= l_cur - V_START;
                pix_r <= r_q;
                pix_g <= g_q;
                pix_b <= b_q;
            end

            frame_start <= vs_fall;
            err         <= err_now;
            if (err_now && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_vga_rx.sv
// Bench for vga_rx: a small video mode is generated frame by frame with random
// colours; the expected pixel stream is derived from the generator's own coordinates.
module tb_vga_rx;

    localparam int HA = 16, HS = 4, HBP = 3, HT = 28;
    localparam int VA = 10, VS = 2, VBP = 3, VT = 18;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hsync = 1'b1, vsync = 1'b1;
    logic [3:0] red = 4'd0, green = 4'd0, blue = 4'd0;
    logic       locked, pix_valid, frame_start, err;
    logic [9:0] pix_x, pix_y;
    logic [3:0] pix_r, pix_g, pix_b;
    logic [7:0] err_count;

    vga_rx #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HBP), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VBP), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .locked(locked), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .frame_start(frame_start), .err(err), .err_count(err_count)
    );

    always #20 clk = ~clk;

    int checks = 0, errors = 0;
    bit exp_locked = 1'b0;
    bit prev_act = 1'b0, prev_fs = 1'b0, last_vs = 1'b1;
    int prev_x = 0, prev_y = 0;
    logic [3:0] prev_r = 4'd0, prev_g = 4'd0, prev_b = 4'd0;
    int vcount, err_seen, err_locked, first_x, first_y, rst_hold = 0;
    bit got_first;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_pix_valid"}, pix_valid, 0);
        check({tag, "_pix_xy"}, {pix_x, pix_y}, 0);
        check({tag, "_pix_rgb"}, {pix_r, pix_g, pix_b}, 0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_err_count"}, err_count, 0);
    endtask

    // one pixel clock: drive pins, then compare outputs against the pixel driven one tick earlier
    task automatic tick(input bit hs, input bit vs, input logic [3:0] r, input logic [3:0] g,
                        input logic [3:0] b, input bit act, input int x, input int y, input bit chk);
        bit exp_v;
        hsync = hs; vsync = vs; red = r; green = g; blue = b;
        @(posedge clk);
        #1;
        if (chk) begin
            exp_v = prev_act && exp_locked;
            check("pix_valid", pix_valid, exp_v);
            if (exp_v) begin
                check("pix_x", pix_x, prev_x);
                check("pix_y", pix_y, prev_y);
                check("pix_rgb", {pix_r, pix_g, pix_b}, {prev_r, prev_g, prev_b});
            end
            check("frame_start", frame_start, prev_fs);
            check("err_quiet", err, 0);
        end else if (err === 1'b1) begin
            err_seen++;
            if (err_seen == 1) err_locked = locked;
        end
        if (pix_valid === 1'b1) begin
            if (!got_first) begin
                got_first = 1'b1; first_x = pix_x; first_y = pix_y;
            end
            vcount++;
        end
        prev_act = act; prev_x = x; prev_y = y;
        prev_r = r; prev_g = g; prev_b = b;
        prev_fs = !vs && last_vs;
        last_vs = vs;
    endtask

    task automatic run_frame(input int n_lines, input int long_line, input int narrow_line,
                             input int rst_at, input bit chk, input bit lock_exp);
        int len, hsw, idx;
        bit act;
        exp_locked = lock_exp;
        vcount = 0; err_seen = 0; err_locked = -1; got_first = 1'b0; idx = 0;
        for (int l = 0; l < n_lines; l++) begin
            len = (l == long_line) ? HT + 1 : HT;
            hsw = (l == narrow_line) ? HS - 1 : HS;
            for (int p = 0; p < len; p++) begin
                act = (p >= HS + HBP) && (p < HS + HBP + HA) && (l >= VS + VBP) && (l < VS + VBP + VA);
                tick(p >= hsw, l >= VS, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), act, p - (HS + HBP), l - (VS + VBP), chk);
                if (idx == rst_at) begin
                    reset = 1'b0;
                    #1;
                    check_zero_outputs("async_reset");
                    rst_hold = 3;
                end else if (rst_hold > 0) begin
                    rst_hold--;
                    if (rst_hold == 0) reset = 1'b1;
                end
                idx++;
            end
        end
        if (chk) begin
            check("valid_count", vcount, lock_exp ? HA * VA : 0);
            if (lock_exp) begin
                check("first_xy", {first_x[15:0], first_y[15:0]}, 0);
                check("last_x_held", pix_x, HA - 1);
                check("last_y_held", pix_y, VA - 1);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset_state");
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick(1, 1, 0, 0, 0, 0, 0, 0, 0);

        // acquisition: first frame aligns, second locks
        run_frame(VT, -1, -1, -1, 1, 0);
        check("align_locked", locked, 0);
        run_frame(VT, -1, -1, -1, 1, 1);
        check("acq_locked", locked, 1);
        check("acq_err_count", err_count, 0);
        run_frame(VT, -1, -1, -1, 1, 1);

        // one stretched line
        run_frame(VT, 5, -1, -1, 0, 1);
        check("long_err_pulses", err_seen, 1);
        check("long_locked_at_err", err_locked, 0);
        check("long_err_count", err_count, 1);
        run_frame(VT, -1, -1, -1, 1, 0);
        run_frame(VT, -1, -1, -1, 1, 1);
        check("relock_after_long", locked, 1);

        // narrow hsync pulse
        run_frame(VT, -1, 7, -1, 0, 1);
        check("narrow_err_pulses", err_seen, 1);
        check("narrow_err_count", err_count, 2);
        check("narrow_search", locked, 0);
        run_frame(VT, -1, -1, -1, 1, 0);
        run_frame(VT, -1, -1, -1, 1, 1);

        // short frame, error lands on the following vsync assertion
        run_frame(VT - 1, -1, -1, -1, 1, 1);
        run_frame(VT, -1, -1, -1, 0, 0);
        check("short_err_pulses", err_seen, 1);
        check("short_err_count", err_count, 3);
        check("short_locked", locked, 0);

        // reset in the middle of an active line, then clean reacquisition
        run_frame(VT, -1, -1, 7 * HT + 12, 0, 0);
        check("post_reset_err_pulses", err_seen, 0);
        check("post_reset_err_count", err_count, 0);
        run_frame(VT, -1, -1, -1, 1, 0);
        run_frame(VT, -1, -1, -1, 1, 1);
        check("final_locked", locked, 1);
        check("final_err_count", err_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
